// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in/serial-out transmit register.
// Accepts one WIDTH-bit word through a valid/ready load handshake and then
// drives it out on ser_out, one bit per shift_en tick. shift_en comes from an
// external bit-rate divider, so the block itself is rate-agnostic.
module piso_shift_tx #(
    parameter int WIDTH     = 8,     // word width, WIDTH >= 2
    parameter bit MSB_FIRST = 1'b1   // 1: bit WIDTH-1 goes out first; 0: bit 0 first
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active-high
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             done
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic             ser_out_nxt;
    logic             ser_valid_nxt;
    logic             done_nxt;

    // Bit presented on the line for a given shift-register content.
    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) return w[WIDTH-1];
        else           return w[0];
    endfunction

    // One shift toward the output end, zero fill at the far end.
    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) return {w[WIDTH-2:0], 1'b0};
        else           return {1'b0, w[WIDTH-1:1]};
    endfunction

    // Ready only while idle; reset masks it immediately, without waiting for a clock.
    assign load_ready = (state == IDLE) && !rst;

    // Next-state and next-output logic for the IDLE/SHIFT controller.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves
        // it unassigned; otherwise synthesis infers a latch to hold the old value.
        state_nxt     = state;
        shreg_nxt     = shreg;
        bit_cnt_nxt   = bit_cnt;
        ser_out_nxt   = 1'b0;
        ser_valid_nxt = 1'b0;
        done_nxt      = 1'b0;

        unique case (state)
            IDLE: begin
                // Load beats any shift_en seen in the same cycle; that tick is dropped.
                if (load_valid) begin
                    state_nxt     = SHIFT;
                    shreg_nxt     = data_in;
                    bit_cnt_nxt   = '0;
                    ser_valid_nxt = 1'b1;
                    ser_out_nxt   = out_bit(data_in);
                end
            end

            SHIFT: begin
                // load_valid and data_in are deliberately ignored for the whole frame.
                ser_valid_nxt = 1'b1;
                ser_out_nxt   = out_bit(shreg);
                if (shift_en) begin
                    if (bit_cnt == LAST_BIT) begin
                        // Last bit period ends: back to idle with a one-cycle done.
                        state_nxt     = IDLE;
                        ser_valid_nxt = 1'b0;
                        ser_out_nxt   = 1'b0;
                        done_nxt      = 1'b1;
                    end else begin
                        shreg_nxt   = shift_once(shreg);
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        ser_out_nxt = out_bit(shift_once(shreg));
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any frame without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            bit_cnt   <= bit_cnt_nxt;
            ser_out   <= ser_out_nxt;
            ser_valid <= ser_valid_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Self-checking bench for piso_shift_tx: an MSB-first and an LSB-first
// instance share one stimulus stream and are compared each cycle against a
// frame-level queue model, plus directed scenarios with literal expectations.
module tb_piso_shift_tx;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load_valid = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             shift_en = 1'b0;

    logic load_ready_m, ser_out_m, ser_valid_m, done_m;
    logic load_ready_l, ser_out_l, ser_valid_l, done_l;

    int n_cmp = 0;
    int n_err = 0;

    // Frame-level model: bits still to be sent, in line order, per instance.
    logic qm[$];
    logic ql[$];
    bit   m_busy = 1'b0;
    bit   m_done = 1'b0;

    // Per-cycle recordings used by the directed scenarios.
    bit   rec = 1'b0;
    logic so_m[$];
    logic so_l[$];
    logic sv_m[$];
    logic dn_m[$];

    piso_shift_tx #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(load_ready_m),
        .data_in(data_in), .shift_en(shift_en),
        .ser_out(ser_out_m), .ser_valid(ser_valid_m), .done(done_m)
    );

    piso_shift_tx #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(load_ready_l),
        .data_in(data_in), .shift_en(shift_en),
        .ser_out(ser_out_l), .ser_valid(ser_valid_l), .done(done_l)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a word becomes a queue of bits; each tick pops one.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_busy = 1'b0;
                m_done = 1'b0;
                qm.delete();
                ql.delete();
            end else begin
                m_done = 1'b0;
                if (!m_busy) begin
                    if (load_valid) begin
                        for (int k = WIDTH - 1; k >= 0; k--) qm.push_back(data_in[k]);
                        for (int k = 0; k < WIDTH; k++)      ql.push_back(data_in[k]);
                        m_busy = 1'b1;
                    end
                end else if (shift_en) begin
                    void'(qm.pop_front());
                    void'(ql.pop_front());
                    if (qm.size() == 0) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end
        end
    end

    // Compare process: every falling edge, all outputs of both instances.
    initial begin
        forever begin
            @(negedge clk);
            check("load_ready_m", load_ready_m, !m_busy && !rst);
            check("load_ready_l", load_ready_l, !m_busy && !rst);
            check("ser_valid_m",  ser_valid_m,  m_busy);
            check("ser_valid_l",  ser_valid_l,  m_busy);
            check("done_m",       done_m,       m_done);
            check("done_l",       done_l,       m_done);
            check("ser_out_m",    ser_out_m,    m_busy ? qm[0] : 1'b0);
            check("ser_out_l",    ser_out_l,    m_busy ? ql[0] : 1'b0);
            if (rec) begin
                so_m.push_back(ser_out_m);
                so_l.push_back(ser_out_l);
                sv_m.push_back(ser_valid_m);
                dn_m.push_back(done_m);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_rec();
        so_m.delete(); so_l.delete(); sv_m.delete(); dn_m.delete();
        rec = 1'b1;
    endtask

    task automatic idle(input int n);
        load_valid = 1'b0;
        shift_en   = 1'b0;
        rec        = 1'b0;
        repeat (n) tick();
    endtask

    // Assemble a word from recorded samples, first-sent bit in the MSB.
    function automatic logic [7:0] word_of(input bit use_l, input int first, input int step);
        logic [7:0] w;
        logic       b;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            b = use_l ? so_l[first + k*step] : so_m[first + k*step];
            w = {w[6:0], b};
        end
        return w;
    endfunction

    function automatic int count_valid();
        int c;
        c = 0;
        foreach (sv_m[i]) if (sv_m[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic int first_done();
        foreach (dn_m[i]) if (dn_m[i] === 1'b1) return i;
        return -1;
    endfunction

    // Accept one word with shift_en every cycle, record n cycles afterwards.
    task automatic send_fast(input logic [7:0] w, input int n);
        load_valid = 1'b1;
        data_in    = w;
        shift_en   = 1'b1;
        tick();
        load_valid = 1'b0;
        start_rec();
        repeat (n) tick();
        idle(2);
    endtask

    initial begin
        int gap;
        int zeros_between;

        // Reset state, held and released.
        repeat (3) tick();
        check("rst_load_ready_m", load_ready_m, 1'b0);
        check("rst_ser_valid_m",  ser_valid_m,  1'b0);
        check("rst_done_l",       done_l,       1'b0);
        rst = 1'b0;
        #1;
        check("post_rst_load_ready_m", load_ready_m, 1'b1);
        check("post_rst_load_ready_l", load_ready_l, 1'b1);
        idle(2);

        // MSB/LSB order with 8'hA5 (a bit palindrome) and 8'h01.
        send_fast(8'hA5, 10);
        check("a5_word_m",    word_of(1'b0, 0, 1), 8'hA5);
        check("a5_word_l",    word_of(1'b1, 0, 1), 8'hA5);
        check("a5_valid_cyc", count_valid(), 8);
        check("a5_done_idx",  first_done(), 8);
        send_fast(8'h01, 10);
        check("01_word_m", word_of(1'b0, 0, 1), 8'h01);
        check("01_word_l", word_of(1'b1, 0, 1), 8'h80);

        // Slow bit rate (tick every 4th cycle) with ignored mid-frame loads.
        load_valid = 1'b1;
        data_in    = 8'h3C;
        tick();
        load_valid = 1'b0;
        start_rec();
        for (int i = 0; i < 40; i++) begin
            shift_en   = (i % 4 == 3);
            load_valid = (i == 5 || i == 13);
            data_in    = (i == 5 || i == 13) ? 8'hFF : 8'h00;
            if (i == 6) check("mid_frame_load_ready", load_ready_m, 1'b0);
            tick();
        end
        idle(2);
        check("3c_word_m",    word_of(1'b0, 0, 4), 8'h3C);
        check("3c_word_l",    word_of(1'b1, 1, 4), 8'h3C);
        check("3c_frame_cyc", count_valid(), 32);
        check("3c_done_idx",  first_done(), 32);

        // Back-to-back frames with load_valid held high.
        load_valid = 1'b1;
        data_in    = 8'hFF;
        shift_en   = 1'b1;
        tick();
        data_in = 8'h00;
        start_rec();
        repeat (9) tick();
        load_valid = 1'b0;
        repeat (10) tick();
        idle(2);
        zeros_between = 0;
        for (int i = 0; i < 17; i++) if (sv_m[i] === 1'b0) zeros_between++;
        gap = first_done();
        check("b2b_valid_cyc", count_valid(), 16);
        check("b2b_gap",       zeros_between, 1);
        check("b2b_done_idx",  gap, 8);
        check("b2b_word1",     word_of(1'b0, 0, 1), 8'hFF);
        check("b2b_word2",     word_of(1'b0, 9, 1), 8'h00);

        // shift_en on the accept edge must not consume bit 0.
        load_valid = 1'b1;
        data_in    = 8'h80;
        shift_en   = 1'b1;
        tick();
        load_valid = 1'b0;
        start_rec();
        for (int i = 0; i < 14; i++) begin
            shift_en = (i >= 3);
            tick();
        end
        idle(2);
        check("80_valid_cyc", count_valid(), 11);
        check("80_hold_bit0", {so_m[0], so_m[1], so_m[2], so_m[3], so_m[4]}, 5'b11110);
        check("80_word_m",    word_of(1'b0, 3, 1), 8'h80);

        // Asynchronous reset between edges in the middle of a frame.
        load_valid = 1'b1;
        data_in    = 8'hFF;
        shift_en   = 1'b1;
        tick();
        load_valid = 1'b0;
        repeat (3) tick();
        #2;
        check("pre_rst_ser_valid", ser_valid_m, 1'b1);
        rst = 1'b1;
        #1;
        check("async_ser_valid_m",  ser_valid_m,  1'b0);
        check("async_ser_out_m",    ser_out_m,    1'b0);
        check("async_ser_out_l",    ser_out_l,    1'b0);
        check("async_done_m",       done_m,       1'b0);
        check("async_load_ready_m", load_ready_m, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        check("rel_load_ready_m", load_ready_m, 1'b1);
        shift_en = 1'b0;
        start_rec();
        repeat (10) tick();
        rec = 1'b0;
        check("rel_no_done", first_done(), -1);

        // Randomized traffic with occasional reset pulses.
        for (int i = 0; i < 4000; i++) begin
            load_valid = ($urandom_range(0, 2) == 0);
            data_in    = WIDTH'($urandom);
            shift_en   = (i < 2000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
            rst        = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
